sdram_arbit: RTL and testbench
==============================

Name: sdram_arbit

Overview:
- Top-level scheduler between the SDRAM init, auto-refresh, write and read sub-modules.
- Owns the refresh interval timer and decides which sub-module owns the shared 20-bit command bus.
- Routes the owning sub-module's bus onto the SDRAM command/address pins.
- Sub-modules are started by a one-cycle enable pulse. Each reports completion on its done output; that output stays high until the sub-module's next start.

Parameters:
- REF_CYCLES, 780, clk cycles between refresh requests (7.8 us at 100 MHz).
- NOP_CMD, 4'b0111, {cs_n,ras_n,cas_n,we_n} driven while no sub-module owns the bus.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- init_done  in  1  init sequence complete (level)
- init_bus  in  20  {cmd[3:0],cke,a[12:0],ba[1:0]} from init
- ref_bus  in  20  same format, from refresh module
- ref_done  in  1  refresh complete (level, rises at end)
- wr_bus  in  20  same format, from write module
- wr_done  in  1  write complete (level, rises at end)
- rd_bus  in  20  same format, from read module
- rd_done  in  1  read complete (level, rises at end)
- wr_req  in  1  user write request (level, held until wr_ack)
- rd_req  in  1  user read request (level, held until rd_ack)
- ref_en  out  1  one-cycle start pulse to refresh module
- wr_en  out  1  one-cycle start pulse to write module
- rd_en  out  1  one-cycle start pulse to read module
- wr_ack  out  1  one-cycle pulse: write accepted (same cycle as wr_en)
- rd_ack  out  1  one-cycle pulse: read accepted (same cycle as rd_en)
- ref_miss  out  1  sticky flag: refresh interval expired while a refresh was still pending
- sdram_cke  out  1  bus bit 15
- sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n}, bus bits 19:16
- sdram_addr  out  13  bus bits 14:2
- sdram_ba  out  2  bus bits 1:0

Behaviour:
- Reset (async, rst_n=0):
  - state=INIT; all en/ack pulses 0; ref_miss=0; timer=0; ref_pend=0; last_grant=READ.
  - Pins follow init_bus.
- States:
  - INIT: waits for init_done=1, then goes to IDLE.
  - IDLE: arbitrates.
  - AREF, WRITE, READ: busy states.
- IDLE decision, evaluated each cycle with fixed priority:
  - ref_pend first → AREF.
  - Else, if wr_req and rd_req are both high, grant the one not in last_grant (round-robin).
  - Else grant whichever request is high.
  - Else stay in IDLE.
- Start pulse:
  - Registered, asserted for exactly the first cycle in the busy state.
  - wr_ack/rd_ack coincide with wr_en/rd_en; last_grant is updated on the grant.
- Completion is the rising edge of the owner's done (done=1 and previous-cycle done=0), tracked per done input.
  - A done level that is stale from the previous operation must not end the state.
  - On completion, return to IDLE the next cycle; a new grant may start the cycle after that.
- Pin mux is combinational on the registered state, so a sub-module's command timing reaches the pins with zero added latency:
  - INIT → init_bus; AREF → ref_bus; WRITE → wr_bus; READ → rd_bus.
  - IDLE → {NOP_CMD, cke=1, a=0, ba=0}.
- Refresh timer:
  - Held at 0 until init_done. Then counts 0..REF_CYCLES-1 and wraps free-running; it is never stalled by busy states.
  - At terminal count it sets ref_pend.
  - ref_pend clears in the cycle ref_en is issued.
  - If terminal count and ref_en occur in the same cycle, ref_pend stays set.
  - If terminal count hits while ref_pend is already set and no ref_en is issued that cycle, ref_miss is set; it clears only on reset.
- A refresh becoming pending during WRITE/READ never preempts; it waits for completion.
- Requests that drop before being granted are simply not served; no memory is kept.
- init_done dropping after INIT is ignored.
- Reset asserted mid-operation: immediate return to INIT; pulses cleared; pins switch to init_bus.

Test Plan:
1. Reset, hold init_done=0 for 50 cycles, then raise it → pins equal init_bus throughout INIT; state IDLE one cycle after init_done; IDLE pins show cmd=4'b0111, cke=1, addr=0, ba=0.
2. From IDLE, wr_req=1 with a write model that raises wr_done 4 cycles after wr_en and holds it high → single wr_en/wr_ack pulse; pins follow wr_bus; IDLE one cycle after the wr_done edge; a stale-high wr_done at the next grant does not end the new write early.
3. wr_req and rd_req held high together for 4 grants → granted order WRITE, READ, WRITE, READ; exactly one en pulse per grant.
4. REF_CYCLES=16; refresh becomes pending during a long write → no preemption; ref_en issued first after write completion even with wr_req/rd_req high; ref_pend clears.
5. REF_CYCLES=16, ref_done never rises (refresh stuck) → ref_miss=1 at the second terminal count after the refresh was granted; it stays 1 until reset.
6. rst_n pulled low during READ → INIT immediately, async with no clk edge needed; rd_en=0; pins = init_bus; timer = 0.

Source files
------------

// File: rtl/sdram_arbit.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbit
// Purpose  : Schedules the SDRAM init / auto-refresh / write / read sub-modules
//            and routes the owning sub-module's 20-bit bus onto the SDRAM pins.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arbit #(
  parameter int         REF_CYCLES = 780,
  parameter logic [3:0] NOP_CMD    = 4'b0111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_init_done,
  input  logic [19:0] i_init_bus,
  input  logic [19:0] i_ref_bus,
  input  logic        i_ref_done,
  input  logic [19:0] i_wr_bus,
  input  logic        i_wr_done,
  input  logic [19:0] i_rd_bus,
  input  logic        i_rd_done,
  input  logic        i_wr_req,
  input  logic        i_rd_req,
  output logic        o_ref_en,
  output logic        o_wr_en,
  output logic        o_rd_en,
  output logic        o_wr_ack,
  output logic        o_rd_ack,
  output logic        o_ref_miss,
  output logic        o_sdram_cke,
  output logic [3:0]  o_sdram_cmd,
  output logic [12:0] o_sdram_addr,
  output logic [1:0]  o_sdram_ba
);

  localparam int          TW         = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
  localparam logic [TW-1:0] C_TC     = TW'(REF_CYCLES - 1);
  localparam logic [19:0] C_IDLE_BUS = {NOP_CMD, 1'b1, 13'd0, 2'd0};

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_timer;
  logic          r_ref_pend;
  logic          r_ref_miss;
  logic          r_last_wr;
  logic          r_ref_en;
  logic          r_wr_en;
  logic          r_rd_en;
  logic          r_ref_done_d;
  logic          r_wr_done_d;
  logic          r_rd_done_d;
  logic          w_grant_ref;
  logic          w_grant_wr;
  logic          w_grant_rd;
  logic          w_tmr_run;
  logic          w_tc;
  logic [19:0]   w_bus;

  // The timer starts with init_done and never looks at it again.
  assign w_tmr_run = (r_state != S_INIT) || i_init_done;
  assign w_tc      = w_tmr_run && (r_timer == C_TC);

  always_comb begin
    w_next      = r_state;
    w_grant_ref = 1'b0;
    w_grant_wr  = 1'b0;
    w_grant_rd  = 1'b0;
    case (r_state)
      S_INIT: begin
        if (i_init_done) w_next = S_IDLE;
      end
      S_IDLE: begin
        if (r_ref_pend) begin
          w_grant_ref = 1'b1;
          w_next      = S_AREF;
        end else if (i_wr_req && (!i_rd_req || !r_last_wr)) begin
          w_grant_wr = 1'b1;
          w_next     = S_WRITE;
        end else if (i_rd_req) begin
          w_grant_rd = 1'b1;
          w_next     = S_READ;
        end
      end
      // Only a fresh rising edge of done ends a busy state.
      S_AREF:  if (i_ref_done && !r_ref_done_d) w_next = S_IDLE;
      S_WRITE: if (i_wr_done && !r_wr_done_d) w_next = S_IDLE;
      S_READ:  if (i_rd_done && !r_rd_done_d) w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_INIT;
      r_timer      <= '0;
      r_ref_pend   <= 1'b0;
      r_ref_miss   <= 1'b0;
      r_last_wr    <= 1'b0;
      r_ref_en     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_ref_done_d <= 1'b0;
      r_wr_done_d  <= 1'b0;
      r_rd_done_d  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_ref_en     <= w_grant_ref;
      r_wr_en      <= w_grant_wr;
      r_rd_en      <= w_grant_rd;
      r_ref_done_d <= i_ref_done;
      r_wr_done_d  <= i_wr_done;
      r_rd_done_d  <= i_rd_done;
      if (w_grant_wr)      r_last_wr <= 1'b1;
      else if (w_grant_rd) r_last_wr <= 1'b0;
      if (w_tmr_run) r_timer <= w_tc ? '0 : r_timer + 1'b1;
      // A terminal count wins over a same-cycle refresh grant.
      if (w_tc) begin
        r_ref_pend <= 1'b1;
        if (r_ref_pend && !w_grant_ref) r_ref_miss <= 1'b1;
      end else if (w_grant_ref) begin
        r_ref_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    w_bus = C_IDLE_BUS;
    case (r_state)
      S_INIT:  w_bus = i_init_bus;
      S_AREF:  w_bus = i_ref_bus;
      S_WRITE: w_bus = i_wr_bus;
      S_READ:  w_bus = i_rd_bus;
      default: w_bus = C_IDLE_BUS;
    endcase
  end

  assign o_sdram_cmd  = w_bus[19:16];
  assign o_sdram_cke  = w_bus[15];
  assign o_sdram_addr = w_bus[14:2];
  assign o_sdram_ba   = w_bus[1:0];
  assign o_ref_en     = r_ref_en;
  assign o_wr_en      = r_wr_en;
  assign o_rd_en      = r_rd_en;
  assign o_wr_ack     = r_wr_en;
  assign o_rd_ack     = r_rd_en;
  assign o_ref_miss   = r_ref_miss;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbit.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_arbit
// Purpose  : Bench for sdram_arbit: vector table, directed corner sequences
//            and a randomized run against an ownership-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbit;

  localparam int          REF        = 16;
  localparam int          O_NONE     = 0;
  localparam int          O_INIT     = 1;
  localparam int          O_IDLE     = 2;
  localparam int          O_REF      = 3;
  localparam int          O_WR       = 4;
  localparam int          O_RD       = 5;
  localparam logic [19:0] C_IDLE_BUS = 20'h78000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0, ref_done = 1'b0, wr_done = 1'b0, rd_done = 1'b0;
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [19:0] init_bus = '0, ref_bus = '0, wr_bus = '0, rd_bus = '0;
  logic        ref_en, wr_en, rd_en, wr_ack, rd_ack, ref_miss, cke;
  logic [3:0]  cmd;
  logic [12:0] addr;
  logic [1:0]  ba;

  int checks = 0;
  int errors = 0;

  // reference model: who owns the bus, which start pulse is visible, refresh bookkeeping
  int m_owner, m_pulse, m_cnt;
  bit m_pend, m_miss, m_lastwr, m_pd_ref, m_pd_wr, m_pd_rd;

  // sub-module stand-ins
  int wr_left = 0, rd_left = 0, ref_left = 0;
  int wr_lat = 4, rd_lat = 4, ref_lat = 3;
  bit ref_stuck = 0, rnd_bus = 0, rnd_req = 0;
  int pe = 0;

  sdram_arbit #(.REF_CYCLES(REF), .NOP_CMD(4'b0111)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_init_done(init_done), .i_init_bus(init_bus),
    .i_ref_bus(ref_bus), .i_ref_done(ref_done),
    .i_wr_bus(wr_bus), .i_wr_done(wr_done),
    .i_rd_bus(rd_bus), .i_rd_done(rd_done),
    .i_wr_req(wr_req), .i_rd_req(rd_req),
    .o_ref_en(ref_en), .o_wr_en(wr_en), .o_rd_en(rd_en),
    .o_wr_ack(wr_ack), .o_rd_ack(rd_ack), .o_ref_miss(ref_miss),
    .o_sdram_cke(cke), .o_sdram_cmd(cmd), .o_sdram_addr(addr), .o_sdram_ba(ba)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] bus_of(input int owner);
    case (owner)
      O_INIT:  return init_bus;
      O_REF:   return ref_bus;
      O_WR:    return wr_bus;
      O_RD:    return rd_bus;
      default: return C_IDLE_BUS;
    endcase
  endfunction

  function automatic logic [31:0] pins();
    return 32'({cmd, cke, addr, ba});
  endfunction

  task automatic model_reset();
    m_owner = O_INIT; m_pulse = O_NONE; m_cnt = 0;
    m_pend = 0; m_miss = 0; m_lastwr = 0;
    m_pd_ref = 0; m_pd_wr = 0; m_pd_rd = 0;
  endtask

  // Predicts the effect of the coming rising edge from the inputs now applied.
  task automatic model_step();
    bit run, tc;
    int grant, nxt;
    run   = (m_owner != O_INIT) || init_done;
    tc    = run && ((m_cnt % REF) == REF - 1);
    grant = O_NONE;
    nxt   = m_owner;
    case (m_owner)
      O_INIT: if (init_done) nxt = O_IDLE;
      O_IDLE: begin
        if (m_pend)                grant = O_REF;
        else if (wr_req && rd_req) grant = m_lastwr ? O_RD : O_WR;
        else if (wr_req)           grant = O_WR;
        else if (rd_req)           grant = O_RD;
      end
      O_REF:  if (ref_done && !m_pd_ref) nxt = O_IDLE;
      O_WR:   if (wr_done && !m_pd_wr) nxt = O_IDLE;
      O_RD:   if (rd_done && !m_pd_rd) nxt = O_IDLE;
      default: nxt = O_INIT;
    endcase
    if (grant != O_NONE) nxt = grant;
    if (grant == O_WR) m_lastwr = 1;
    else if (grant == O_RD) m_lastwr = 0;
    if (tc) begin
      if (m_pend && grant != O_REF) m_miss = 1;
      m_pend = 1;
    end else if (grant == O_REF) begin
      m_pend = 0;
    end
    if (run) m_cnt++;
    m_pd_ref = ref_done; m_pd_wr = wr_done; m_pd_rd = rd_done;
    m_owner = nxt;
    m_pulse = grant;
  endtask

  task automatic model_check();
    chk("pins", pins(), 32'(bus_of(m_owner)));
    chk("en", 32'({ref_en, wr_en, rd_en}),
        32'({m_pulse == O_REF, m_pulse == O_WR, m_pulse == O_RD}));
    chk("ack", 32'({wr_ack, rd_ack}), 32'({m_pulse == O_WR, m_pulse == O_RD}));
    chk("ref_miss", 32'(ref_miss), 32'(m_miss));
    chk("ref_pend", 32'(dut.r_ref_pend), 32'(m_pend));
  endtask

  task automatic submodels();
    if (wr_en) begin
      wr_done = 0; wr_left = rnd_req ? int'($urandom_range(1, 8)) : wr_lat;
    end else if (wr_left > 0) begin
      wr_left--; if (wr_left == 0) wr_done = 1;
    end
    if (rd_en) begin
      rd_done = 0; rd_left = rnd_req ? int'($urandom_range(1, 8)) : rd_lat;
    end else if (rd_left > 0) begin
      rd_left--; if (rd_left == 0) rd_done = 1;
    end
    if (ref_en) begin
      ref_done = 0; ref_left = ref_stuck ? 0 : ref_lat;
    end else if (ref_left > 0) begin
      ref_left--; if (ref_left == 0) ref_done = 1;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    pe++;
    model_check();
    submodels();
    if (rnd_bus) begin
      init_bus = 20'($urandom); ref_bus = 20'($urandom);
      wr_bus   = 20'($urandom); rd_bus  = 20'($urandom);
    end
    if (rnd_req) begin
      init_done = ($urandom_range(0, 7) == 0);
      if (wr_ack) wr_req = 0;
      else if (!wr_req) wr_req = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 19) == 0) wr_req = 0;
      if (rd_ack) rd_req = 0;
      else if (!rd_req) rd_req = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 19) == 0) rd_req = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    wr_req = 0; rd_req = 0; wr_done = 0; rd_done = 0; ref_done = 0;
    wr_left = 0; rd_left = 0; ref_left = 0;
    model_reset();
    #1;
    chk("rst_pins", pins(), 32'(init_bus));
    chk("rst_pulses", 32'({ref_en, wr_en, rd_en, wr_ack, rd_ack}), 0);
    chk("rst_miss", 32'(ref_miss), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    pe = 0;
  endtask

  typedef struct {
    logic id, wq, rq, wd, rdn;
    int   own;
    logic we, re;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int   grants[$];
    int   first;
    bit   seen, saw_pend;

    // ---------------- table-driven sequence ----------------
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_INIT, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_INIT, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_WR,   1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_WR,   1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_IDLE, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, O_RD,   1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_RD,   1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_IDLE, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, O_WR,   1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_WR,   1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_WR,   1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_IDLE, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_RD,   1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_RD,   1'b0, 1'b0};

    init_bus = 20'h1ABCD; ref_bus = 20'h2A5A5; wr_bus = 20'h4F00F; rd_bus = 20'h5C3C3;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      init_done = vecs[i].id; wr_req = vecs[i].wq; rd_req = vecs[i].rq;
      wr_done = vecs[i].wd; rd_done = vecs[i].rdn;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_pins", i), pins(), 32'(bus_of(vecs[i].own)));
      chk($sformatf("vec%0d_en", i), 32'({ref_en, wr_en, rd_en}), 32'({1'b0, vecs[i].we, vecs[i].re}));
      chk($sformatf("vec%0d_ack", i), 32'({wr_ack, rd_ack}), 32'({vecs[i].we, vecs[i].re}));
    end

    // ---------------- long INIT, then idle pins ----------------
    init_done = 0; rnd_bus = 1;
    do_reset();
    repeat (50) step();
    init_done = 1;
    step();
    chk("idle_pins", pins(), 32'(C_IDLE_BUS));
    rnd_bus = 0;

    // ---------------- round robin under constant contention ----------------
    do_reset();
    init_done = 1;
    step();
    wr_req = 1; rd_req = 1;
    for (int n = 0; n < 300 && grants.size() < 4; n++) begin
      step();
      if (wr_en) grants.push_back(O_WR);
      if (rd_en) grants.push_back(O_RD);
    end
    chk("rr_count", 32'(grants.size()), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk($sformatf("rr_order%0d", i), 32'(grants[i]), (i % 2 == 0) ? 32'(O_WR) : 32'(O_RD));

    // ---------------- refresh pending during a long write ----------------
    do_reset();
    init_done = 1; wr_lat = 20;
    step();
    wr_req = 1;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin step(); seen = wr_en; end
    chk("d_wr_grant", 32'(seen), 1);
    rd_req = 1;
    first = O_NONE; saw_pend = 0;
    for (int n = 0; n < 60 && first == O_NONE; n++) begin
      step();
      if (dut.r_ref_pend) saw_pend = 1;
      if (ref_en) first = O_REF;
      else if (wr_en) first = O_WR;
      else if (rd_en) first = O_RD;
    end
    chk("d_pend_in_write", 32'(saw_pend), 1);
    chk("d_first_after_write", 32'(first), 32'(O_REF));
    chk("d_pend_cleared", 32'(dut.r_ref_pend), 0);
    wr_lat = 4;

    // ---------------- stuck refresh -> ref_miss ----------------
    // grant follows the first terminal count (edge 16) at edge 17;
    // the next counts land on edges 32 and 48, the latter misses.
    do_reset();
    init_done = 1; ref_stuck = 1;
    while (pe < 47) step();
    chk("e_miss_before", 32'(ref_miss), 0);
    step();
    chk("e_miss_at_tc", 32'(ref_miss), 1);
    repeat (20) step();
    chk("e_miss_sticky", 32'(ref_miss), 1);
    ref_stuck = 0;

    // ---------------- async reset during READ ----------------
    do_reset();
    init_done = 1; rd_lat = 10;
    step();
    rd_req = 1;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin step(); seen = rd_en; end
    chk("f_rd_grant", 32'(seen), 1);
    #2;
    rst_n = 0;
    #1;
    chk("f_pins", pins(), 32'(init_bus));
    chk("f_rd_en", 32'({rd_en, rd_ack}), 0);
    chk("f_timer", 32'(dut.r_timer), 0);
    rd_lat = 4;

    // ---------------- randomized run ----------------
    rnd_bus = 1; rnd_req = 1; init_done = 0;
    do_reset();
    repeat (3000) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
